dmem_arbiter_rr_n: RTL and testbench

- Parametrised N-master round-robin arbiter for the shared data-memory port. It is the successor to the fixed two-master D$/PTW arbiter.
- Masters are the core D$, PTW, DMA and debug. Each master carries a full RW request: we, be, addr, wdata.
- Round-robin is rotating-priority with a starvation yield timer. Handoff to the next master is zero-bubble: it happens in the same cycle the current transaction completes.
- Sits between the master-side request mux and the single dmem slave.

---
 rtl/dmem_arbiter_rr_n.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_arbiter_rr_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_rr_n.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dmem_arbiter_rr_n
//   N-master round-robin arbiter for the shared data-memory port.
//   Rotating priority starts from rr_ptr. A starvation yield timer revokes a
//   grant that stalls for MAX_WAIT cycles while another master is waiting.
//   Handoff is zero-bubble: when the owner completes, the next grant is
//   registered on that same clock edge.
//
//   Optional feature macro: DMEM_ARB_LOCK_EN
//     When it is defined, the m_lock port is added. An owner that completes
//     with m_lock set keeps the grant, and its yield timer is disabled.
//     The lock is released by the first completion with m_lock clear.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   m_req/we     per-master request (held until rvalid) and write enable
//   m_be         per-master byte enables, master i at [i*BE_W +: BE_W]
//   m_addr       per-master address,      master i at [i*ADDR_W +: ADDR_W]
//   m_wdata      per-master write data,   master i at [i*DATA_W +: DATA_W]
//   m_lock       per-master lock request (DMEM_ARB_LOCK_EN only)
//   m_rdata      broadcast read data, qualified by m_rvalid
//   m_rvalid     one-hot completion to the owner
//   m_fault      one-hot fault, valid only with m_rvalid
//   mem_*        single dmem slave port
//   grant        registered one-hot owner, 0 when idle
//   yield_evt    registered one-cycle pulse on a timeout revoke
// ---------------------------------------------------------------------------
module dmem_arbiter_rr_n #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_WAIT    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_be,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]            m_lock,
`endif
    output logic [DATA_W-1:0]                 m_rdata,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [NUM_MASTERS-1:0]            m_fault,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [DATA_W/8-1:0]               mem_be,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_rvalid,
    input  logic                              mem_fault,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              yield_evt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WC_W  = $clog2(MAX_WAIT) + 1;

    logic [NUM_MASTERS-1:0] grant_r;
    logic [NUM_MASTERS-1:0] grant_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       rr_ptr_nxt_s;
    logic [WC_W-1:0]        wait_cnt_r;
    logic [WC_W-1:0]        wait_cnt_nxt_s;
    logic                   yield_r;
    logic                   yield_nxt_s;

    logic [IDX_W-1:0]       owner_idx_s;
    logic                   owner_valid_s;
    logic                   owner_req_s;
    logic                   others_req_s;
    logic [IDX_W-1:0]       ptr_inc_s;
    logic                   locked_s;
    logic                   lock_now_s;

    logic [BE_W-1:0]        be_arr_s    [NUM_MASTERS];
    logic [ADDR_W-1:0]      addr_arr_s  [NUM_MASTERS];
    logic [DATA_W-1:0]      wdata_arr_s [NUM_MASTERS];

    // First requester at or after 'start', searching with wrap-around.
    // The request vector is rotated so that 'start' lands on bit 0. The
    // lowest set bit is then isolated, and the result is rotated back.
    function automatic logic [NUM_MASTERS-1:0] pick_f(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       start
    );
        logic [2*NUM_MASTERS-1:0] dbl;
        logic [NUM_MASTERS-1:0]   rot;
        logic [NUM_MASTERS-1:0]   hot;
        logic [NUM_MASTERS-1:0]   sel;
        logic                     found;
        dbl   = {req, req} >> start;
        rot   = dbl[NUM_MASTERS-1:0];
        hot   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (rot[0] && !found) begin
                sel   = hot;
                found = 1'b1;
            end else begin
                sel   = sel;
            end
            rot = rot >> 1;
            hot = hot << 1;
        end
        dbl = {sel, sel} << start;
        return dbl[2*NUM_MASTERS-1:NUM_MASTERS];
    endfunction

    // Unpack the flat master buses into per-master arrays.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign be_arr_s[g]    = m_be[g*BE_W +: BE_W];
        assign addr_arr_s[g]  = m_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr_s[g] = m_wdata[g*DATA_W +: DATA_W];
    end

    // Encode the one-hot grant into the owner index.
    always_comb begin
        logic [NUM_MASTERS-1:0] g_tmp;
        owner_idx_s = '0;
        g_tmp       = grant_r;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g_tmp[0]) begin
                owner_idx_s = IDX_W'(i);
            end else begin
                owner_idx_s = owner_idx_s;
            end
            g_tmp = g_tmp >> 1;
        end
    end

    assign owner_valid_s = |grant_r;
    assign owner_req_s   = owner_valid_s & m_req[owner_idx_s];
    assign others_req_s  = |(m_req & ~grant_r);
    assign ptr_inc_s     = (owner_idx_s == IDX_W'(NUM_MASTERS - 1)) ? IDX_W'(0)
                                                                   : owner_idx_s + IDX_W'(1);

`ifdef DMEM_ARB_LOCK_EN
    logic lock_r;
    assign locked_s   = lock_r;
    assign lock_now_s = owner_valid_s & m_lock[owner_idx_s];

    // The lock follows the owner's m_lock on each completion. Any grant change clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r <= 1'b0;
        end else if (grant_nxt_s != grant_r) begin
            lock_r <= 1'b0;
        end else if (owner_valid_s && mem_rvalid) begin
            lock_r <= lock_now_s;
        end else begin
            lock_r <= lock_r;
        end
    end
`else
    assign locked_s   = 1'b0;
    assign lock_now_s = 1'b0;
`endif

    // Arbitration: next owner, rotation pointer, yield timer, and timeout pulse.
    always_comb begin
        grant_nxt_s    = grant_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        wait_cnt_nxt_s = wait_cnt_r;
        yield_nxt_s    = 1'b0;
        if (!owner_valid_s) begin
            grant_nxt_s    = pick_f(m_req, rr_ptr_r);
            wait_cnt_nxt_s = '0;
        end else if (mem_rvalid) begin
            wait_cnt_nxt_s = '0;
            if (lock_now_s) begin
                grant_nxt_s = grant_r;
            end else begin
                // Searching from the new pointer gives zero-bubble handoff in rotating order.
                rr_ptr_nxt_s = ptr_inc_s;
                grant_nxt_s  = pick_f(m_req & ~grant_r, ptr_inc_s);
            end
        end else if (!owner_req_s) begin
            // The owner withdrew before completion: cancel, with no rvalid produced.
            grant_nxt_s    = pick_f(m_req & ~grant_r, rr_ptr_r);
            wait_cnt_nxt_s = '0;
        end else if (others_req_s && !locked_s) begin
            if (wait_cnt_r == WC_W'(MAX_WAIT - 1)) begin
                rr_ptr_nxt_s   = ptr_inc_s;
                grant_nxt_s    = pick_f(m_req & ~grant_r, ptr_inc_s);
                wait_cnt_nxt_s = '0;
                yield_nxt_s    = 1'b1;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + WC_W'(1);
            end
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // State registers. Reset drops the grant immediately, which abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r    <= '0;
            rr_ptr_r   <= '0;
            wait_cnt_r <= '0;
            yield_r    <= 1'b0;
        end else begin
            grant_r    <= grant_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            yield_r    <= yield_nxt_s;
        end
    end

    // The slave port follows the registered owner, and all fields are zero when idle.
    // mem_req also drops when the owner withdraws, which the slave sees as a cancel.
    assign mem_req   = owner_req_s;
    assign mem_we    = owner_valid_s & m_we[owner_idx_s];
    assign mem_be    = owner_valid_s ? be_arr_s[owner_idx_s]    : '0;
    assign mem_addr  = owner_valid_s ? addr_arr_s[owner_idx_s]  : '0;
    assign mem_wdata = owner_valid_s ? wdata_arr_s[owner_idx_s] : '0;

    // Completion is routed to the owner. A stray rvalid while idle reaches nobody.
    assign m_rdata   = mem_rdata;
    assign m_rvalid  = grant_r & {NUM_MASTERS{mem_rvalid}};
    assign m_fault   = grant_r & {NUM_MASTERS{mem_rvalid & mem_fault}};

    assign grant     = grant_r;
    assign yield_evt = yield_r;

endmodule

// File: tb/tb_dmem_arbiter_rr_n.sv
`timescale 1ns/1ps
module tb_dmem_arbiter_rr_n;

    logic        clk;
    logic        rst;
    logic [3:0]  m_req;
    logic [3:0]  m_we;
    logic [15:0] m_be;
    logic [127:0] m_addr;
    logic [127:0] m_wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic [3:0]  m_lock;
`endif
    logic [31:0] m_rdata;
    logic [3:0]  m_rvalid;
    logic [3:0]  m_fault;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_fault;
    logic [3:0]  grant;
    logic        yield_evt;

    dmem_arbiter_rr_n #(
        .NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .m_lock(m_lock),
`endif
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_fault(m_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_fault(mem_fault), .grant(grant), .yield_evt(yield_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  we;
        logic        rv;
        logic        flt;
        logic [31:0] rdata;
        logic [3:0]  eg;
        logic        emr;
        logic        emw;
        logic [3:0]  erv;
        logic [3:0]  ef;
        logic        ey;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_v = -1;

    // Per-master payload that the bench drives. These are also the expected mem_* values.
    logic [31:0] exp_addr  [4] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300};
    logic [31:0] exp_wdata [4] = '{32'hA000_0000, 32'h1234_ABCD, 32'hA000_0002, 32'hA000_0003};
    logic [3:0]  exp_be    [4] = '{4'hF, 4'b0011, 4'hF, 4'hF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, cur_v, act, exp);
        end
    endtask

    task automatic add_v(input logic r, input logic [3:0] req, input logic [3:0] we,
                         input logic rv, input logic flt, input logic [31:0] rd,
                         input logic [3:0] eg, input logic emr, input logic emw,
                         input logic [3:0] erv, input logic [3:0] ef, input logic ey);
        vec_t v;
        v.rst = r;   v.req = req; v.we = we;  v.rv = rv;   v.flt = flt; v.rdata = rd;
        v.eg = eg;   v.emr = emr; v.emw = emw; v.erv = erv; v.ef = ef;  v.ey = ey;
        vecs.push_back(v);
    endtask

    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        case (v)
            4'b0001: oh_idx = 2'd0;
            4'b0010: oh_idx = 2'd1;
            4'b0100: oh_idx = 2'd2;
            4'b1000: oh_idx = 2'd3;
            default: oh_idx = 2'd0;
        endcase
    endfunction

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int t_first;
        int t_last;
        int n_y;
        int cyc;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  eb;

        rst = 1'b1; m_req = 4'h0; m_we = 4'h0;
        mem_rdata = 32'h0; mem_rvalid = 1'b0; mem_fault = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        m_lock = 4'h0;
`endif
        m_addr  = {exp_addr[3],  exp_addr[2],  exp_addr[1],  exp_addr[0]};
        m_wdata = {exp_wdata[3], exp_wdata[2], exp_wdata[1], exp_wdata[0]};
        m_be    = {exp_be[3],    exp_be[2],    exp_be[1],    exp_be[0]};

        //     rst req      we       rv   flt  rdata          eg       emr  emw  erv      ef       ey
        // Reset state, then a single read from master 2 with a 3-cycle slave.
        add_v(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // A stray rvalid/fault while idle reaches no master.
        add_v(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h5555AAAA, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // All four masters with a 1-cycle slave: completion order 0,1,2,3,0 with no bubbles.
        add_v(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h00000010, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h00000011, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h00000012, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h00000013, 4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h00000014, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        // Master 1 owns but drops its request: a cancel with mem_req low, and then idle.
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Yield: master 0 stalls while master 3 waits. The grant moves after 8 cycles.
        add_v(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 8; k++)
            add_v(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 32'h0,    4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b1000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
        add_v(1'b0, 4'b1001, 4'b0000, 1'b1, 1'b0, 32'h00000033, 4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h00000030, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Write from master 1 with a slave fault. The fault is seen only in the rvalid cycle.
        add_v(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 32'h0,        4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 32'h00000021, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Reset mid-grant drops the grant without a clock edge. Arbitration then restarts at master 0.
        add_v(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0, 32'h00000040, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 32'h00000042, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
        add_v(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        repeat (2) @(negedge clk);
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            cur_v      = k;
            rst        = vecs[k].rst;
            m_req      = vecs[k].req;
            m_we       = vecs[k].we;
            mem_rvalid = vecs[k].rv;
            mem_fault  = vecs[k].flt;
            mem_rdata  = vecs[k].rdata;
            #2;
            ea = (vecs[k].eg == 4'b0000) ? 32'h0 : exp_addr[oh_idx(vecs[k].eg)];
            ew = (vecs[k].eg == 4'b0000) ? 32'h0 : exp_wdata[oh_idx(vecs[k].eg)];
            eb = (vecs[k].eg == 4'b0000) ? 4'h0  : exp_be[oh_idx(vecs[k].eg)];
            chk("grant",     {28'h0, grant},     {28'h0, vecs[k].eg});
            chk("mem_req",   {31'h0, mem_req},   {31'h0, vecs[k].emr});
            chk("mem_we",    {31'h0, mem_we},    {31'h0, vecs[k].emw});
            chk("m_rvalid",  {28'h0, m_rvalid},  {28'h0, vecs[k].erv});
            chk("m_fault",   {28'h0, m_fault},   {28'h0, vecs[k].ef});
            chk("yield_evt", {31'h0, yield_evt}, {31'h0, vecs[k].ey});
            chk("mem_addr",  mem_addr,  ea);
            chk("mem_wdata", mem_wdata, ew);
            chk("mem_be",    {28'h0, mem_be}, {28'h0, eb});
            if (vecs[k].erv != 4'b0000)
                chk("m_rdata", m_rdata, vecs[k].rdata);
        end

        // Starvation bound: all four masters request and the slave never answers.
        // Master 3 must own the port exactly 3*MAX_WAIT cycles after master 0.
        cur_v = 1000;
        @(negedge clk); rst = 1'b1; m_req = 4'h0; mem_rvalid = 1'b0; mem_fault = 1'b0;
        @(negedge clk); rst = 1'b0; m_req = 4'hF;
        t_first = -1; t_last = -1; n_y = 0; cyc = 0;
        while (cyc < 100 && t_last < 0) begin
            @(negedge clk); #2;
            cyc++;
            if (yield_evt) n_y++;
            if (grant == 4'b0001 && t_first < 0) t_first = cyc;
            if (grant == 4'b1000) t_last = cyc;
        end
        chk("starve_reached", {31'h0, (t_last >= 0)}, 32'd1);
        chk("starve_first",   t_first, 32'd1);
        chk("starve_span",    t_last - t_first, 32'd24);
        chk("starve_yields",  n_y, 32'd3);
        @(negedge clk); m_req = 4'h0;

`ifdef DMEM_ARB_LOCK_EN
        // Master 2 locked for three transactions while master 0 waits.
        cur_v = 2000;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; m_req = 4'b0100; m_lock = 4'b0100;
        @(negedge clk); m_req = 4'b0101; mem_rvalid = 1'b1; #2;
        chk("lock_c1", {28'h0, m_rvalid}, {28'h0, 4'b0100});
        @(negedge clk); mem_rvalid = 1'b0; #2;
        chk("lock_hold", {28'h0, grant}, {28'h0, 4'b0100});
        n_y = 0; cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #2;
            if (yield_evt) n_y++;
            if (grant != 4'b0100) cyc++;
        end
        chk("lock_no_yield", n_y, 32'd0);
        chk("lock_no_move",  cyc, 32'd0);
        @(negedge clk); mem_rvalid = 1'b1; #2;
        chk("lock_c2", {28'h0, m_rvalid}, {28'h0, 4'b0100});
        @(negedge clk); m_lock = 4'b0000; #2;
        chk("lock_c3", {28'h0, m_rvalid}, {28'h0, 4'b0100});
        @(negedge clk); mem_rvalid = 1'b0; m_req = 4'b0001; #2;
        chk("lock_release", {28'h0, grant}, {28'h0, 4'b0001});
        @(negedge clk); m_req = 4'h0;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
